// File: rtl/maze_rom_arbiter.sv
// maze_rom_arbiter: shares the maze ROM between video fetch and round-robin game wall checks; optional starvation flags under MAZE_ARB_STARVE_EN
module maze_rom_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int COLS     = 640,
  parameter int ROWS     = 480,
  parameter int ADDR_W   = 19,
  parameter int MAX_WAIT = 1023
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    vid_active,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic                    vid_data,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [10*NUM_REQ-1:0]   req_x,
  input  logic [10*NUM_REQ-1:0]   req_y,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    rsp_data,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic                    rom_data,
  output logic [NUM_REQ-1:0]      starve
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {T_NONE, T_VID, T_REQ, T_OOR} tag_t;
  tag_t tag, tag_d;
  logic [PW-1:0] rr_ptr, sel, idx;
  logic found, oor;
  logic [9:0] rx [NUM_REQ];
  logic [9:0] ry [NUM_REQ];
  logic [ADDR_W-1:0] addr_q;
  logic vid_q, rsp_q;

  function automatic logic [ADDR_W-1:0] xy_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rx[i] = req_x[10*i +: 10];
    assign ry[i] = req_y[10*i +: 10];
  end

  // round-robin scan starting just after the last granted requester
  always_comb begin
    found = 1'b0;
    sel = rr_ptr;
    idx = rr_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end

  // issue: video owns the ROM when visible, otherwise the selected requester
  always_comb begin
    oor = int'(rx[sel]) >= COLS || int'(ry[sel]) >= ROWS;
    gnt = (Reset_n && !vid_active && found) ? NUM_REQ'(1) << sel : '0;
    rom_addr = vid_active ? xy_addr(DrawX, DrawY) : (found && !oor) ? xy_addr(rx[sel], ry[sel]) : addr_q;
    tag_d = vid_active ? T_VID : !found ? T_NONE : oor ? T_OOR : T_REQ;
  end

  // return routing: ROM data lands the cycle after issue, steered by the registered tag
  always_comb begin
    vid_data = tag == T_VID ? rom_data : vid_q;
    rsp_data = tag == T_REQ ? rom_data : tag == T_OOR ? 1'b1 : rsp_q;
  end

  // issue tag, pointer, held address and held return data
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tag <= T_NONE;
      rr_ptr <= PW'(NUM_REQ - 1);
      addr_q <= '0;
      rsp_valid <= '0;
      vid_q <= 1'b0;
      rsp_q <= 1'b0;
    end else begin
      tag <= tag_d;
      addr_q <= rom_addr;
      rsp_valid <= gnt;
      vid_q <= vid_data;
      rsp_q <= rsp_data;
      if (!vid_active && found) rr_ptr <= sel;
    end
  end

`ifdef MAZE_ARB_STARVE_EN
  logic [9:0] wait_cnt [NUM_REQ];

  // per-requester wait counters with sticky starvation flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      starve <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) wait_cnt[i] <= '0;
        else if (req[i] && wait_cnt[i] != 10'(MAX_WAIT)) wait_cnt[i] <= wait_cnt[i] + 10'd1;
        if (req[i] && !gnt[i] && wait_cnt[i] == 10'(MAX_WAIT - 1)) starve[i] <= 1'b1;
      end
    end
  end
`else
  assign starve = {NUM_REQ{MAX_WAIT < 0}};
`endif
endmodule
